data_memory_controller: RTL and testbench

- Responder end of the CPU's single-cycle memory bus: serves combinational reads and clocked byte/half/word writes.
- Backs a byte-addressed, little-endian data RAM.
- Decodes a small MMIO window holding a console TX FIFO (drained over a valid/ready byte stream) and a free-running 64-bit cycle counter.
- Sits beside the CPU core at SoC top level, wired directly to its memory_* ports.

---
 rtl/memctrl_pkg.sv | 47 ++++
 rtl/data_memory_controller_sync_fifo.sv | 49 ++++
 rtl/data_memory_controller.sv | 122 ++++++++++++
 tb/tb_data_memory_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/memctrl_pkg.sv
// Shared encodings for the data memory controller: write widths, MMIO offsets, STATUS bits.
// Also provides the bus width macros when the surrounding SoC has not already defined them.
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 32
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

package memctrl_pkg;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10,
        W_RSVD = 2'b11
    } width_e;

    localparam logic [3:0] OFF_TX       = 4'h0;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_CYCLE_LO = 4'h8;
    localparam logic [3:0] OFF_CYCLE_HI = 4'hC;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef struct packed {
        logic        en;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_req_t;

    // Byte lanes touched by a write, counted upward from the write address.
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] w);
        case (w)
            W_BYTE:  lane_mask = 4'b0001;
            W_HALF:  lane_mask = 4'b0011;
            W_WORD:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction
endpackage

// File: rtl/data_memory_controller_sync_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/data_memory_controller.sv
// Single-cycle memory bus responder: little-endian data RAM plus MMIO console TX FIFO
// and cycle counter. Define MEMCTRL_CYCLE_COUNTER_EN to build the 64-bit cycle counter.
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 32
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

module data_memory_controller
    import memctrl_pkg::*;
#(
    parameter int          RAM_BYTES     = 4096,
    parameter string       RAM_INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
    parameter int          FIFO_DEPTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [`MEMORY_DEPTH-1:0]  memory_read_address,
    output logic [`MEMORY_WIDTH-1:0]  memory_read_data,
    input  logic [1:0]                memory_write_width,
    input  logic [`MEMORY_DEPTH-1:0]  memory_write_address,
    input  logic [`MEMORY_WIDTH-1:0]  memory_write_data,
    input  logic                      memory_write_enable,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic                      tx_overflow
);
    localparam int AW = $clog2(RAM_BYTES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [LANE_W-1:0] mem [RAM_BYTES];

    wr_req_t wr;
    assign wr = '{en: memory_write_enable, width: memory_write_width,
                  addr: memory_write_address, data: memory_write_data};

    logic rd_in_ram, rd_in_mmio, wr_in_ram, wr_in_mmio, wr_ok;
    assign rd_in_ram  = (memory_read_address[31:AW] == '0);
    assign wr_in_ram  = (wr.addr[31:AW] == '0);
    assign rd_in_mmio = (memory_read_address[31:4] == MMIO_BASE[31:4]);
    assign wr_in_mmio = (wr.addr[31:4] == MMIO_BASE[31:4]);
    assign wr_ok      = wr.en && (wr.width != W_RSVD);

    // Byte lanes wrap independently at the top of RAM, so misaligned access is free.
    logic [NUM_LANES-1:0][LANE_W-1:0] ram_rd;
    logic [NUM_LANES-1:0]             wr_lanes;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_rd
        assign ram_rd[i] = mem[AW'(memory_read_address[AW-1:0] + AW'(i))];
    end

    assign wr_lanes = (wr.en && wr_in_ram) ? lane_mask(wr.width) : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_lanes[i]) mem[AW'(wr.addr[AW-1:0] + AW'(i))] <= wr.data[i*LANE_W +: LANE_W];
        end
    end

    logic          tx_push, tx_pop, ovf_clr, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;

    assign tx_push  = wr_ok && wr_in_mmio && (wr.addr[3:0] == OFF_TX);
    assign ovf_clr  = wr_ok && wr_in_mmio && (wr.addr[3:0] == OFF_STATUS) && wr.data[ST_OVF];
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !fifo_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (wr.data[7:0]),
        .pop       (tx_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt),
        .head      (tx_data)
    );

    // A dropped push outranks a same-edge software clear.
    always_ff @(posedge clk) begin
        if (!rst_n)                                  tx_overflow <= 1'b0;
        else if (tx_push && fifo_full && !tx_pop)    tx_overflow <= 1'b1;
        else if (ovf_clr)                            tx_overflow <= 1'b0;
    end

    logic [63:0] cycle_cnt;
`ifdef MEMCTRL_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst_n) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + 64'd1;
    end
`else
    assign cycle_cnt = '0;
`endif

    logic [31:0] status;
    always_comb begin
        status                          = '0;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_FULL]                 = fifo_full;
        status[ST_OVF]                  = tx_overflow;
        status[ST_CNT_LSB +: 8]         = 8'(fifo_cnt);
    end

    always_comb begin
        memory_read_data = '0;
        if (rd_in_ram) begin
            memory_read_data = ram_rd;
        end else if (rd_in_mmio) begin
            case (memory_read_address[3:0])
                OFF_STATUS:   memory_read_data = status;
                OFF_CYCLE_LO: memory_read_data = cycle_cnt[31:0];
                OFF_CYCLE_HI: memory_read_data = cycle_cnt[63:32];
                default:      memory_read_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: RAM byte lanes and wrap, MMIO TX FIFO, cycle counter.
module tb_data_memory_controller;
    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] memory_read_address;
    logic [31:0] memory_read_data;
    logic [1:0]  memory_write_width;
    logic [31:0] memory_write_address;
    logic [31:0] memory_write_data;
    logic        memory_write_enable;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_overflow;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_memory_controller dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .memory_read_address  (memory_read_address),
        .memory_read_data     (memory_read_data),
        .memory_write_width   (memory_write_width),
        .memory_write_address (memory_write_address),
        .memory_write_data    (memory_write_data),
        .memory_write_enable  (memory_write_enable),
        .tx_valid             (tx_valid),
        .tx_data              (tx_data),
        .tx_ready             (tx_ready),
        .tx_overflow          (tx_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        memory_write_address = a;
        memory_write_data    = d;
        memory_write_width   = w;
        memory_write_enable  = 1'b1;
        tick();
        memory_write_enable  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        memory_read_address = a;
        #1;
        d = memory_read_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  exp_q [8];

        rst_n = 1'b0;
        memory_read_address = '0;
        memory_write_width = 2'b10;
        memory_write_address = '0;
        memory_write_data = '0;
        memory_write_enable = 1'b0;
        tx_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_overflow", tx_overflow, 0);
        rd(MB + 4, d); chk("rst_status", d, 32'h0000_0001);

        // word write and misaligned reads
        wr(32'h14, 32'h0000_0077, 2'b10);
        wr(32'h10, 32'hDEAD_BEEF, 2'b10);
        rd(32'h10, d); chk("rd_0x10", d, 32'hDEAD_BEEF);
        rd(32'h11, d); chk("rd_0x11", d, 32'h77DE_ADBE);
        rd(32'h12, d); chk("rd_0x12", d, 32'h0077_DEAD);

        // byte write over word, with read-during-write
        wr(32'h20, 32'h1122_3344, 2'b10);
        memory_read_address  = 32'h20;
        memory_write_address = 32'h21;
        memory_write_data    = 32'hFFFF_FF5A;
        memory_write_width   = 2'b00;
        memory_write_enable  = 1'b1;
        #1 chk("rdw_old", memory_read_data, 32'h1122_3344);
        tick();
        memory_write_enable = 1'b0;
        rd(32'h20, d); chk("rdw_new", d, 32'h1122_5A44);

        // half write
        wr(32'h40, 32'h5566_7788, 2'b10);
        wr(32'h40, 32'hAAAA_1234, 2'b01);
        rd(32'h40, d); chk("half_wr", d, 32'h5566_1234);

        // wrap at top of RAM
        wr(32'h0000_0FFE, 32'hA1B2_C3D4, 2'b10);
        rd(32'h0000_0FFE, d); chk("wrap_rd", d, 32'hA1B2_C3D4);
        rd(32'h0, d); chk("wrap_low", {16'h0, d[15:0]}, 32'h0000_A1B2);

        // reserved width ignored, unmapped ignored
        wr(32'h30, 32'hCAFE_F00D, 2'b10);
        wr(32'h30, 32'h0000_0000, 2'b11);
        rd(32'h30, d); chk("rsvd_width", d, 32'hCAFE_F00D);
        wr(32'h2000_0000, 32'h1234_5678, 2'b10);
        rd(32'h2000_0000, d); chk("unmapped", d, 32'h0);
        rd(MB + 32'h0, d); chk("tx_reads_0", d, 32'h0);
        rd(MB + 32'h5, d); chk("mmio_hole", d, 32'h0);

        // fill FIFO past full with sink stalled
        for (int i = 0; i < 9; i++) wr(MB, 32'h41 + i, 2'b00);
        rd(MB + 4, d); chk("status_full", d, 32'h0000_0806);
        chk("ovf_set", tx_overflow, 1);
        chk("head_first", tx_data, 8'h41);

        // pop and push while full: count holds
        tx_ready = 1'b1;
        wr(MB, 32'h7E, 2'b10);
        rd(MB + 4, d); chk("full_pushpop", d, 32'h0000_0806);
        chk("ovf_hold", tx_overflow, 1);

        for (int i = 0; i < 7; i++) exp_q[i] = 8'(8'h42 + i);
        exp_q[7] = 8'h7E;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid%0d", i), tx_valid, 1);
            chk($sformatf("drain_data%0d", i), tx_data, exp_q[i]);
            tick();
        end
        chk("drained", tx_valid, 0);
        rd(MB + 4, d); chk("status_empty_ovf", d, 32'h0000_0005);

        // clear overflow, partial fill
        tx_ready = 1'b0;
        wr(MB + 4, 32'h4, 2'b10);
        chk("ovf_clr", tx_overflow, 0);
        for (int i = 0; i < 3; i++) wr(MB, 32'h30 + i, 2'b00);
        rd(MB + 4, d); chk("status_cnt3", d, 32'h0000_0300);

        // reset mid-stream discards queued bytes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_valid", tx_valid, 0);
        rd(MB + 4, d); chk("rst_mid_status", d, 32'h0000_0001);
        rd(32'h40, d); chk("ram_survives_rst", d, 32'h5566_1234);

        for (int i = 0; i < 5; i++) tick();
`ifdef MEMCTRL_CYCLE_COUNTER_EN
        rd(MB + 8, d); chk("cyc_lo_n", d, 32'd5);
        rd(MB + 12, d); chk("cyc_hi_n", d, 32'd0);
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        tick();
        rd(MB + 8, d); chk("cyc_lo_carry", d, 32'd0);
        rd(MB + 12, d); chk("cyc_hi_carry", d, 32'd1);
`else
        rd(MB + 8, d); chk("cyc_lo_off", d, 32'd0);
        rd(MB + 12, d); chk("cyc_hi_off", d, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
